// File: rtl/fifo_pkt_pkg.sv
// Shared types for the FIFO packet reader: FSM encoding, header field position
// and the bundle of one-cycle strobes the reader drives.
package fifo_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_RESP,
    ST_RBWAIT
  } state_e;

  // Length field sits at the bottom of the header word.
  localparam int HDR_LEN_LSB = 0;

  // Cycles the FSM idles after a pointer move before trusting fifo_empty.
  localparam int PTR_SETTLE = 2;

  typedef struct packed {
    logic read_en;
    logic snap;
    logic rollback;
    logic reset_ptr;
    logic done;
    logic drop;
  } strobe_t;

endpackage

// File: rtl/fifo_pkt_reader.sv
// Reads length-prefixed packets out of a FIFO one beat at a time, replays on NAK
// via the FIFO snapshot/rollback pointer controls, and drops after MAX_RETRY replays.
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LEN_W     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             rdclk,
  input  logic             rd_rstn,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] read_data,
  output logic             read_en,
  output logic             sanpshot_rdptr,
  output logic             rollback_rdptr,
  output logic             reset_rdptr,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  input  logic             resp_valid,
  input  logic             resp_nak,
  input  logic             flush,
  output logic             pkt_done,
  output logic             pkt_drop
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [1:0]    SETTLE    = 2'(PTR_SETTLE);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [1:0]       hold_q, hold_d;
  strobe_t          stb_q, stb_d;
  logic [WIDTH-1:0] m_data_d;
  logic             m_valid_d, m_last_d;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_len = read_data[HDR_LEN_LSB +: LEN_W];

  // State register
  always_ff @(posedge rdclk or negedge rd_rstn) begin
    if (!rd_rstn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (hold_q == 2'd0 && !fifo_empty) state_d = ST_LOAD;
        ST_FETCH:  if (!fifo_empty) state_d = ST_LOAD;
        ST_LOAD:   state_d = ST_SEND;
        ST_SEND:   if (m_ready) state_d = m_last ? ST_RESP : ST_FETCH;
        ST_RESP:   if (resp_valid)
                     state_d = (resp_nak && retry_q != RETRY_LIM) ? ST_RBWAIT : ST_IDLE;
        ST_RBWAIT: if (hold_q == 2'd0) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values; everything leaves through flops
  always_comb begin
    stb_d     = '0;
    m_data_d  = m_data;
    m_valid_d = m_valid;
    m_last_d  = m_last;
    beat_d    = beat_q;
    len_d     = len_q;
    retry_d   = retry_q;
    hold_d    = (hold_q != 2'd0) ? 2'(hold_q - 2'd1) : 2'd0;
    if (flush) begin
      stb_d.reset_ptr = 1'b1;
      m_data_d        = '0;
      m_valid_d       = 1'b0;
      m_last_d        = 1'b0;
      beat_d          = '0;
      retry_d         = '0;
      hold_d          = SETTLE;
    end else begin
      case (state_q)
        ST_IDLE: if (hold_q == 2'd0 && !fifo_empty) begin
          stb_d.read_en = 1'b1;
          stb_d.snap    = 1'b1;
          beat_d        = '0;
        end
        ST_FETCH: if (!fifo_empty) stb_d.read_en = 1'b1;
        ST_LOAD: begin
          m_data_d  = read_data;
          m_valid_d = 1'b1;
          if (beat_q == '0) begin
            len_d    = hdr_len;
            m_last_d = (hdr_len == '0);
          end else begin
            m_last_d = (beat_q == len_q);
          end
        end
        ST_SEND: if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          beat_d    = beat_q + 1'b1;
        end
        ST_RESP: if (resp_valid) begin
          if (!resp_nak) begin
            stb_d.done = 1'b1;
            retry_d    = '0;
          end else if (retry_q != RETRY_LIM) begin
            stb_d.rollback = 1'b1;
            retry_d        = retry_q + 1'b1;
            // RBWAIT spans this count plus the cycle it reaches zero
            hold_d         = SETTLE - 2'd1;
          end else begin
            stb_d.drop = 1'b1;
            retry_d    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rdclk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      stb_q   <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      beat_q  <= '0;
      len_q   <= '0;
      retry_q <= '0;
      hold_q  <= 2'd0;
    end else begin
      stb_q   <= stb_d;
      m_data  <= m_data_d;
      m_valid <= m_valid_d;
      m_last  <= m_last_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      retry_q <= retry_d;
      hold_q  <= hold_d;
    end
  end

  assign read_en        = stb_q.read_en;
  assign sanpshot_rdptr = stb_q.snap;
  assign rollback_rdptr = stb_q.rollback;
  assign reset_rdptr    = stb_q.reset_ptr;
  assign pkt_done       = stb_q.done;
  assign pkt_drop       = stb_q.drop;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed + randomized bench: a pointer-based FIFO model feeds the reader and the
// expected beat stream / strobe counts are derived from the packet contents and NAK plan.
module tb_fifo_pkt_reader;
  localparam int WIDTH = 32, LEN_W = 8, MAX_RETRY = 3;

  logic rdclk = 1'b0, rd_rstn = 1'b0;
  logic fifo_empty, read_en, sanpshot_rdptr, rollback_rdptr, reset_rdptr;
  logic [WIDTH-1:0] read_data, m_data;
  logic m_valid, m_last, m_ready, pkt_done, pkt_drop;
  logic resp_valid = 1'b0, resp_nak = 1'b0, flush = 1'b0;
  logic ready_dir = 1'b0, rnd_en = 1'b0, rnd_rdy = 1'b0;

  int n_tests = 0, n_fail = 0;

  always #5 rdclk = ~rdclk;

  fifo_pkt_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W), .MAX_RETRY(MAX_RETRY)) dut (
    .rdclk(rdclk), .rd_rstn(rd_rstn), .fifo_empty(fifo_empty), .read_data(read_data),
    .read_en(read_en), .sanpshot_rdptr(sanpshot_rdptr), .rollback_rdptr(rollback_rdptr),
    .reset_rdptr(reset_rdptr), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .resp_valid(resp_valid), .resp_nak(resp_nak), .flush(flush),
    .pkt_done(pkt_done), .pkt_drop(pkt_drop));

  assign m_ready = rnd_en ? rnd_rdy : ready_dir;
  always @(negedge rdclk) rnd_rdy <= 1'($urandom_range(0, 1));

  // FIFO model: word array with write, read and snapshot pointers
  logic [WIDTH-1:0] mem [0:1023];
  int wrptr = 0, rdptr = 0, snap = 0;
  assign fifo_empty = (rdptr == wrptr);
  assign read_data  = mem[rdptr[9:0]];

  always @(posedge rdclk) begin
    if (!rd_rstn || reset_rdptr) rdptr <= wrptr;
    else if (rollback_rdptr)     rdptr <= snap;
    else if (read_en)            rdptr <= rdptr + 1;
    if (sanpshot_rdptr) snap <= rdptr;
  end

  // Monitor: accepted beats and strobe counts
  logic [WIDTH-1:0] got_data[$];
  bit got_last[$];
  int got_cyc[$];
  int cyc = 0, c_snap = 0, c_rb = 0, c_rst = 0, c_done = 0, c_drop = 0, c_bad = 0;
  always @(posedge rdclk) begin
    cyc++;
    if (m_valid && m_ready) begin
      got_data.push_back(m_data); got_last.push_back(m_last); got_cyc.push_back(cyc);
    end
    if (sanpshot_rdptr) c_snap++;
    if (rollback_rdptr) c_rb++;
    if (reset_rdptr)    c_rst++;
    if (pkt_done)       c_done++;
    if (pkt_drop)       c_drop++;
    if (read_en && fifo_empty) c_bad++;
  end

  logic [WIDTH-1:0] pkt[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mk_pkt(input int n);
    logic [WIDTH-1:0] hdr;
    pkt.delete();
    hdr = $urandom();
    hdr[LEN_W-1:0] = n[LEN_W-1:0];
    pkt.push_back(hdr);
    for (int i = 0; i < n; i++) pkt.push_back($urandom());
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    mem[wrptr[9:0]] = w;
    wrptr = wrptr + 1;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int b = 0;
    while (got_data.size() < target && b < budget) begin @(negedge rdclk); b++; end
    if (got_data.size() < target) chk({tag, "_timeout"}, 64'(got_data.size()), 64'(target));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int b = 0;
    while (!m_valid && b < budget) begin @(negedge rdclk); b++; end
    if (!m_valid) chk({tag, "_valid_timeout"}, 64'(m_valid), 64'd1);
  endtask

  task automatic respond(input bit nak);
    resp_valid = 1'b1; resp_nak = nak;
    @(negedge rdclk);
    resp_valid = 1'b0; resp_nak = 1'b0;
  endtask

  // Push pkt, answer each pass per the NAK plan, then compare against the expected outcome
  task automatic do_pkt(input int naks, input string tag);
    int n = pkt.size() - 1;
    int passes = ((naks < MAX_RETRY) ? naks : MAX_RETRY) + 1;
    int base = got_data.size();
    int s0 = c_snap, r0 = c_rb, d0 = c_done, x0 = c_drop;
    foreach (pkt[i]) push_word(pkt[i]);
    for (int p = 0; p < passes; p++) begin
      wait_beats(tag, base + (p + 1) * (n + 1), 600);
      respond(p < naks);
    end
    repeat (4) @(negedge rdclk);
    chk({tag, "_beats"}, 64'(got_data.size() - base), 64'(passes * (n + 1)));
    for (int i = 0; i < passes * (n + 1); i++) begin
      chk({tag, "_data"}, 64'(got_data[base + i]), 64'(pkt[i % (n + 1)]));
      chk({tag, "_last"}, 64'(got_last[base + i]), 64'((i % (n + 1)) == n));
    end
    chk({tag, "_snap"}, 64'(c_snap - s0), 64'(passes));
    chk({tag, "_rollback"}, 64'(c_rb - r0), 64'(passes - 1));
    chk({tag, "_done"}, 64'(c_done - d0), 64'(naks <= MAX_RETRY));
    chk({tag, "_drop"}, 64'(c_drop - x0), 64'(naks > MAX_RETRY));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, 64'({read_en, sanpshot_rdptr, rollback_rdptr, pkt_done, pkt_drop}), 64'd0);
    chk({tag, "_vld_last"}, 64'({m_valid, m_last}), 64'd0);
    chk({tag, "_mdata"}, 64'(m_data), 64'd0);
  endtask

  initial begin
    int base, d0, x0, r0, n;
    repeat (3) @(negedge rdclk);
    chk_quiet("reset");
    chk("reset_rstptr", 64'(reset_rdptr), 64'd0);
    rd_rstn = 1'b1;
    ready_dir = 1'b1;

    // N=2 header with payload 0xA, 0xB, plain ACK, and 3-cycle beat spacing
    pkt.delete(); pkt.push_back(32'h2); pkt.push_back(32'hA); pkt.push_back(32'hB);
    base = got_data.size();
    do_pkt(0, "ack");
    chk("rate_b1", 64'(got_cyc[base + 1] - got_cyc[base]), 64'd3);
    chk("rate_b2", 64'(got_cyc[base + 2] - got_cyc[base + 1]), 64'd3);

    do_pkt(2, "nak2");   // two replays then ACK
    do_pkt(4, "nak4");   // retries exhausted -> drop
    mk_pkt(1);
    do_pkt(0, "after_drop");

    pkt.delete(); pkt.push_back(32'h100);
    do_pkt(0, "n0");

    // Underrun: N=3 but only header + 1 payload word present at first
    mk_pkt(3);
    base = got_data.size(); d0 = c_done;
    push_word(pkt[0]); push_word(pkt[1]);
    wait_beats("underrun_a", base + 2, 100);
    repeat (10) @(negedge rdclk);
    chk("underrun_stall", 64'(got_data.size() - base), 64'd2);
    chk("underrun_no_rd", 64'(c_bad), 64'd0);
    push_word(pkt[2]); push_word(pkt[3]);
    wait_beats("underrun_b", base + 4, 100);
    respond(1'b0);
    repeat (3) @(negedge rdclk);
    for (int i = 0; i < 4; i++) chk("underrun_data", 64'(got_data[base + i]), 64'(pkt[i]));
    chk("underrun_last", 64'(got_last[base + 3]), 64'd1);
    chk("underrun_done", 64'(c_done - d0), 64'd1);

    // Backpressure: header must hold while m_ready is low
    ready_dir = 1'b0;
    mk_pkt(2);
    foreach (pkt[i]) push_word(pkt[i]);
    base = got_data.size();
    wait_valid("stall", 50);
    for (int i = 0; i < 5; i++) begin
      @(negedge rdclk);
      chk("stall_valid", 64'(m_valid), 64'd1);
      chk("stall_data", 64'(m_data), 64'(pkt[0]));
    end
    ready_dir = 1'b1;
    wait_beats("stall", base + 3, 100);
    respond(1'b0);
    repeat (3) @(negedge rdclk);
    for (int i = 0; i < 3; i++) chk("stall_seq", 64'(got_data[base + i]), 64'(pkt[i]));

    // Flush while beat 1 is presented
    ready_dir = 1'b0;
    mk_pkt(2);
    foreach (pkt[i]) push_word(pkt[i]);
    base = got_data.size(); d0 = c_done; x0 = c_drop; r0 = c_rst;
    wait_valid("flush_hdr", 50);
    ready_dir = 1'b1; @(negedge rdclk); ready_dir = 1'b0;
    wait_valid("flush_b1", 50);
    chk("flush_b1_data", 64'(m_data), 64'(pkt[1]));
    flush = 1'b1; @(negedge rdclk); flush = 1'b0;
    chk("flush_rstptr", 64'(reset_rdptr), 64'd1);
    chk_quiet("flush");
    repeat (5) @(negedge rdclk);
    chk("flush_rst_cnt", 64'(c_rst - r0), 64'd1);
    chk("flush_no_status", 64'((c_done - d0) + (c_drop - x0)), 64'd0);
    chk("flush_beats", 64'(got_data.size() - base), 64'd1);
    ready_dir = 1'b1;
    mk_pkt(1);
    do_pkt(0, "post_flush");

    // Reset asserted while a beat waits in SEND
    ready_dir = 1'b0;
    mk_pkt(3);
    foreach (pkt[i]) push_word(pkt[i]);
    d0 = c_done; x0 = c_drop;
    wait_valid("rst_send", 50);
    rd_rstn = 1'b0; #1;
    chk_quiet("rst_async");
    repeat (2) @(negedge rdclk);
    rd_rstn = 1'b1;
    repeat (3) @(negedge rdclk);
    chk("rst_no_status", 64'((c_done - d0) + (c_drop - x0)), 64'd0);
    ready_dir = 1'b1;
    mk_pkt(2);
    do_pkt(1, "post_rst");

    // Randomized packets under random backpressure
    rnd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(0, 5);
      mk_pkt(n);
      do_pkt($urandom_range(0, 4), "rnd");
    end
    rnd_en = 1'b0;

    chk("rd_while_empty", 64'(c_bad), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
